// File: rtl/jtframe_pulse_stretch_if.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_pulse_stretch_if
// Brief    : Control, trigger and status bundle for the pulse stretcher.
// Revision : 1.0 - initial release
// ============================================================================
interface jtframe_pulse_stretch_if #(
  parameter int CH = 4,
  parameter int W  = 14
);
  logic          cen;
  logic          retrig;
  logic [W-1:0]  len;
  logic [W-1:0]  gap;
  logic [CH-1:0] pulse_in;
  logic [CH-1:0] pulse_out;
  logic [CH-1:0] busy;
  logic          any_out;

  modport master (
    output cen, retrig, len, gap, pulse_in,
    input  pulse_out, busy, any_out
  );

  modport slave (
    input  cen, retrig, len, gap, pulse_in,
    output pulse_out, busy, any_out
  );
endinterface
`default_nettype wire

// File: rtl/jtframe_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_pulse_stretch
// Brief    : Multi-channel pulse stretcher with retrigger and hold-off window.
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_pulse_stretch #(
  parameter int CH      = 4,
  parameter int W       = 14,
  parameter int SYNC    = 2,
  parameter int EDGE    = 0,
  parameter int INIT_ON = 0
) (
  input  wire                    clk,
  input  wire                    rst,
  jtframe_pulse_stretch_if.slave bus
);

  localparam logic [W-1:0] c_CNT_ONES = {W{1'b1}};
  localparam logic [W-1:0] c_CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] c_CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic         c_INIT     = (INIT_ON != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam state_t c_ST_RST = (INIT_ON != 0) ? ST_ACTIVE : ST_IDLE;

  logic [CH-1:0] w_s;
  logic [CH-1:0] r_s_d;
  logic [CH-1:0] w_trig;
  logic [CH-1:0] w_nxt_active;
  logic          r_any;

  generate
    if (SYNC > 0) begin : g_sync
      logic [CH-1:0] r_sync [SYNC];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC; i++) r_sync[i] <= '0;
        end else begin
          r_sync[0] <= bus.pulse_in;
          for (int i = 1; i < SYNC; i++) r_sync[i] <= r_sync[i-1];
        end
      end

      assign w_s = r_sync[SYNC-1];
    end else begin : g_nosync
      assign w_s = bus.pulse_in;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_s_d <= '0;
    else     r_s_d <= w_s;
  end

  assign w_trig = (EDGE != 0) ? (w_s & ~r_s_d) : w_s;

  generate
    for (genvar g = 0; g < CH; g++) begin : g_ch
      state_t       r_state;
      state_t       w_state_nxt;
      logic [W-1:0] r_cnt;
      logic [W-1:0] w_cnt_nxt;
      logic         r_pulse;
      logic         r_busy;

      // Retrigger outranks expiry; expiry is evaluated every clk regardless of cen.
      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
          ST_IDLE: begin
            if (w_trig[g]) begin
              w_state_nxt = ST_ACTIVE;
              w_cnt_nxt   = bus.len;
            end
          end
          ST_ACTIVE: begin
            if (w_trig[g] && bus.retrig) begin
              w_cnt_nxt = bus.len;
            end else if (r_cnt == c_CNT_ZERO) begin
              if (bus.gap != c_CNT_ZERO) begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = bus.gap;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end else if (bus.cen) begin
              w_cnt_nxt = r_cnt - c_CNT_ONE;
            end
          end
          ST_HOLD: begin
            if (r_cnt == c_CNT_ZERO) begin
              w_state_nxt = ST_IDLE;
            end else if (bus.cen) begin
              w_cnt_nxt = r_cnt - c_CNT_ONE;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = c_CNT_ZERO;
          end
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= c_ST_RST;
          r_cnt   <= c_INIT ? c_CNT_ONES : c_CNT_ZERO;
          r_pulse <= c_INIT;
          r_busy  <= c_INIT;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
          r_pulse <= (w_state_nxt == ST_ACTIVE);
          r_busy  <= (w_state_nxt != ST_IDLE);
        end
      end

      assign w_nxt_active[g]  = (w_state_nxt == ST_ACTIVE);
      assign bus.pulse_out[g] = r_pulse;
      assign bus.busy[g]      = r_busy;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_any <= c_INIT;
    else     r_any <= |w_nxt_active;
  end

  assign bus.any_out = r_any;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_pulse_stretch
// Brief    : Directed bench for level, edge and INIT_ON stretcher variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_pulse_stretch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtframe_pulse_stretch_if #(.CH(4), .W(14)) ifa ();
  jtframe_pulse_stretch_if #(.CH(4), .W(14)) ifb ();
  jtframe_pulse_stretch_if #(.CH(4), .W(4))  ifc ();

  jtframe_pulse_stretch #(.CH(4), .W(14), .SYNC(2), .EDGE(0), .INIT_ON(0))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  jtframe_pulse_stretch #(.CH(4), .W(14), .SYNC(2), .EDGE(1), .INIT_ON(0))
    u_b (.clk(clk), .rst(rst), .bus(ifb));
  jtframe_pulse_stretch #(.CH(4), .W(4),  .SYNC(2), .EDGE(0), .INIT_ON(1))
    u_c (.clk(clk), .rst(rst), .bus(ifc));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;
  bit cen_div = 1'b0;

  int   hi_a [4];
  int   busy_a0, any_a, rise_a0, first_a0;
  int   hi_b0, hi_b1, busy_b0, rise_b0;
  int   hi_c0, any_c;
  logic prev_a0 = 1'b0;
  logic prev_b0 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < 4; c++) if (ifa.pulse_out[c]) hi_a[c]++;
      if (ifa.busy[0]) busy_a0++;
      if (ifa.any_out) any_a++;
      if (ifa.pulse_out[0] && !prev_a0) rise_a0++;
      if (ifa.pulse_out[0] && first_a0 < 0) first_a0 = cyc;
      if (ifb.pulse_out[0]) hi_b0++;
      if (ifb.pulse_out[1]) hi_b1++;
      if (ifb.busy[0]) busy_b0++;
      if (ifb.pulse_out[0] && !prev_b0) rise_b0++;
      if (ifc.pulse_out[0]) hi_c0++;
      if (ifc.any_out) any_c++;
    end
    prev_a0 = ifa.pulse_out[0];
    prev_b0 = ifb.pulse_out[0];
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    foreach (hi_a[c]) hi_a[c] = 0;
    busy_a0 = 0; any_a = 0; rise_a0 = 0; first_a0 = -1;
    hi_b0 = 0; hi_b1 = 0; busy_b0 = 0; rise_b0 = 0;
    hi_c0 = 0; any_c = 0;
  endtask

  // Advance to the next falling edge; cen for ifa is set for the coming rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifa.cen = cen_div ? (((cyc + 1) % 4) == 0) : 1'b1;
    end
  endtask

  // One-clk pulse on ifa channel 0; a second one sep clk later when sep > 0.
  task automatic pulses_a(input int sep);
    ifa.pulse_in[0] = 1'b1;
    t0 = cyc;
    step(1);
    ifa.pulse_in[0] = 1'b0;
    if (sep > 0) begin
      step(sep - 1);
      ifa.pulse_in[0] = 1'b1;
      step(1);
      ifa.pulse_in[0] = 1'b0;
    end
  endtask

  task automatic edges_b(input int sep);
    clear_counts();
    step(1);
    ifb.pulse_in[0] = 1'b1;
    step(1);
    ifb.pulse_in[0] = 1'b0;
    step(sep - 1);
    ifb.pulse_in[0] = 1'b1;
    step(1);
    ifb.pulse_in[0] = 1'b0;
    step(30);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end of run, expected finish");
    $fatal(1);
  end

  initial begin
    ifa.cen = 1'b1; ifa.retrig = 1'b0; ifa.len = 14'd5; ifa.gap = 14'd0; ifa.pulse_in = '0;
    ifb.cen = 1'b1; ifb.retrig = 1'b0; ifb.len = 14'd4; ifb.gap = 14'd3; ifb.pulse_in = '0;
    ifc.cen = 1'b1; ifc.retrig = 1'b0; ifc.len = 4'd2;  ifc.gap = 4'd0;  ifc.pulse_in = '0;
    clear_counts();
    step(3);

    check("rst_a_pulse", int'(ifa.pulse_out), 0);
    check("rst_a_busy",  int'(ifa.busy), 0);
    check("rst_a_any",   int'(ifa.any_out), 0);
    check("rst_c_pulse", int'(ifc.pulse_out), 15);
    check("rst_c_busy",  int'(ifc.busy), 15);
    check("rst_c_any",   int'(ifc.any_out), 1);

    // INIT_ON channel counts down 15..0 then expires: 16 clk high from release.
    clear_counts();
    @(posedge clk);
    #1 rst = 1'b0;
    step(25);
    check("init_c_width", hi_c0, 16);
    check("init_c_any",   any_c, 16);
    check("init_a_quiet", hi_a[0], 0);

    // Single 1-clk input, len=5, cen=1.
    clear_counts();
    step(1);
    pulses_a(0);
    step(15);
    check("t1_width",   hi_a[0], 6);
    check("t1_latency", first_a0 - t0, 3);
    check("t1_busy",    busy_a0, 6);
    check("t1_any",     any_a, 6);
    check("t1_others",  hi_a[1] + hi_a[2] + hi_a[3], 0);

    // cen every 4th clk, load lands 1 clk before a cen tick.
    ifa.len = 14'd3;
    cen_div = 1'b1;
    clear_counts();
    step(1);
    while ((cyc % 4) != 0) step(1);
    pulses_a(0);
    step(20);
    check("t2_width", hi_a[0], 10);
    check("t2_busy",  busy_a0, 10);
    cen_div = 1'b0;

    ifa.len = 14'd4;
    ifa.retrig = 1'b1;
    clear_counts();
    step(1);
    pulses_a(3);
    step(15);
    check("t3_retrig_width", hi_a[0], 8);
    check("t3_retrig_rises", rise_a0, 1);

    ifa.retrig = 1'b0;
    clear_counts();
    step(1);
    pulses_a(3);
    step(15);
    check("t3_drop_width", hi_a[0], 5);
    check("t3_drop_rises", rise_a0, 1);

    // Level input held 20 clk, len=2, gap=0.
    ifa.len = 14'd2;
    ifa.retrig = 1'b1;
    clear_counts();
    step(1);
    ifa.pulse_in[0] = 1'b1;
    step(20);
    ifa.pulse_in[0] = 1'b0;
    step(10);
    check("lvl_retrig_width", hi_a[0], 22);
    check("lvl_retrig_rises", rise_a0, 1);

    ifa.retrig = 1'b0;
    clear_counts();
    step(1);
    ifa.pulse_in[0] = 1'b1;
    step(20);
    ifa.pulse_in[0] = 1'b0;
    step(10);
    check("lvl_rep_width", hi_a[0], 15);
    check("lvl_rep_rises", rise_a0, 5);
    check("lvl_rep_busy",  busy_a0, 15);

    // Edge mode, len=4, gap=3: each pulse is 5 high + 4 hold.
    edges_b(10);
    check("t4_sep10_width", hi_b0, 10);
    check("t4_sep10_busy",  busy_b0, 18);
    check("t4_sep10_rises", rise_b0, 2);
    edges_b(6);
    check("t4_sep6_width", hi_b0, 5);
    check("t4_sep6_busy",  busy_b0, 9);
    edges_b(9);
    check("t4_sep9_width", hi_b0, 5);
    check("t4_sep9_rises", rise_b0, 1);

    clear_counts();
    step(1);
    ifb.pulse_in[1] = 1'b1;
    step(20);
    ifb.pulse_in[1] = 1'b0;
    step(15);
    check("edge_hold_width", hi_b1, 5);

    // Asynchronous reset while every channel is active.
    ifa.len = 14'd100;
    step(1);
    ifa.pulse_in = 4'hF;
    step(1);
    ifa.pulse_in = 4'h0;
    step(6);
    check("t6_active", int'(ifa.pulse_out), 15);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_pulse", int'(ifa.pulse_out), 0);
    check("t6_rst_busy",  int'(ifa.busy), 0);
    check("t6_rst_any",   int'(ifa.any_out), 0);
    check("t6_rst_c",     int'(ifc.pulse_out), 15);
    step(3);
    @(posedge clk);
    #1 rst = 1'b0;

    ifa.len = 14'd5;
    clear_counts();
    step(2);
    pulses_a(0);
    step(15);
    check("t6_after_width",   hi_a[0], 6);
    check("t6_after_latency", first_a0 - t0, 3);
    check("t6_after_others",  hi_a[1] + hi_a[2] + hi_a[3], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
